// File: rtl/edusoc_arb_pkg.sv
// Shared types and constants for the EduSoC data-port arbiter.
// Optional slave-response timeout is enabled by defining ARB_TIMEOUT_EN.
package edusoc_arb_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } arb_state_t;

    localparam logic [31:0] ARB_ERR_PATTERN = 32'hDEADBEEF;

    function automatic int idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/edusoc_rr_select.sv
// Combinational round-robin picker: first requester at or after ptr,
// wrapping modulo N.
module edusoc_rr_select
    import edusoc_arb_pkg::*;
#(
    parameter int N  = 2,
    parameter int IW = 1
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic [N-1:0]  o_gnt,
    output logic [IW-1:0] o_idx,
    output logic          o_any
);

    // Scan offsets from farthest to nearest so the nearest requester wins.
    always_comb begin : p_pick
        int j;
        j     = 0;
        o_gnt = '0;
        o_idx = '0;
        for (int k = N - 1; k >= 0; k--) begin
            j = (int'(i_ptr) + k) % N;
            if (i_req[j]) begin
                o_gnt    = '0;
                o_gnt[j] = 1'b1;
                o_idx    = IW'(j);
            end
        end
    end

    assign o_any = |i_req;

endmodule

// File: rtl/edusoc_data_arbiter.sv
// N-master round-robin arbiter onto the single EduSoC DATA port.
// Define ARB_TIMEOUT_EN to enable the local slave-response timeout.
module edusoc_data_arbiter
    import edusoc_arb_pkg::*;
#(
    parameter int N_MASTERS      = 2,
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 255,
    localparam int BE_W          = DATA_W / 8
) (
    input  logic                          CLK,
    input  logic                          RESN,
    input  logic [N_MASTERS-1:0]          M_REQ,
    input  logic [N_MASTERS-1:0]          M_WE,
    input  logic [N_MASTERS*BE_W-1:0]     M_BE,
    input  logic [N_MASTERS*ADDR_W-1:0]   M_ADDR,
    input  logic [N_MASTERS*DATA_W-1:0]   M_WDATA,
    output logic [N_MASTERS-1:0]          M_VALID,
    output logic [DATA_W-1:0]             M_RDATA,
    output logic                          M_ERR,
    output logic                          S_REQ,
    output logic                          S_WE,
    output logic [BE_W-1:0]               S_BE,
    output logic [ADDR_W-1:0]             S_ADDR,
    output logic [DATA_W-1:0]             S_WDATA,
    input  logic                          S_VALID,
    input  logic [DATA_W-1:0]             S_RDATA,
    output logic [N_MASTERS-1:0]          GRANT
);

    localparam int IW = idx_w(N_MASTERS);

    arb_state_t            r_state;
    arb_state_t            w_state_nxt;
    logic [IW-1:0]         r_ptr;
    logic [IW-1:0]         r_idx;
    logic [IW-1:0]         w_sel_idx;
    logic [N_MASTERS-1:0]  r_grant;
    logic [N_MASTERS-1:0]  w_sel_gnt;
    logic                  w_any;
    logic                  w_accept;
    logic                  w_done;
    logic                  w_timeout;
    logic                  w_err;
    logic [DATA_W-1:0]     w_err_data;

    logic                  r_s_req;
    logic                  r_s_we;
    logic [BE_W-1:0]       r_s_be;
    logic [ADDR_W-1:0]     r_s_addr;
    logic [DATA_W-1:0]     r_s_wdata;

    edusoc_rr_select #(
        .N  (N_MASTERS),
        .IW (IW)
    ) u_rr_select (
        .i_req (M_REQ),
        .i_ptr (r_ptr),
        .o_gnt (w_sel_gnt),
        .o_idx (w_sel_idx),
        .o_any (w_any)
    );

    always_ff @(posedge CLK or negedge RESN) begin
        if (!RESN) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_done      = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_any) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (S_VALID || w_timeout) begin
                    w_done      = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESN) begin
        if (!RESN) begin
            r_ptr     <= '0;
            r_idx     <= '0;
            r_grant   <= '0;
            r_s_req   <= 1'b0;
            r_s_we    <= 1'b0;
            r_s_be    <= '0;
            r_s_addr  <= '0;
            r_s_wdata <= '0;
        end else if (w_accept) begin
            r_grant   <= w_sel_gnt;
            r_idx     <= w_sel_idx;
            r_s_req   <= 1'b1;
            r_s_we    <= M_WE[w_sel_idx];
            r_s_be    <= M_BE[w_sel_idx*BE_W +: BE_W];
            r_s_addr  <= M_ADDR[w_sel_idx*ADDR_W +: ADDR_W];
            r_s_wdata <= M_WDATA[w_sel_idx*DATA_W +: DATA_W];
        end else if (w_done) begin
            r_grant <= '0;
            r_s_req <= 1'b0;
            r_ptr   <= (r_idx == IW'(N_MASTERS - 1)) ? '0 : r_idx + IW'(1);
        end
    end

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge CLK or negedge RESN) begin
        if (!RESN) begin
            r_cnt <= '0;
        end else if (w_accept) begin
            r_cnt <= '0;
        end else if (r_state == ST_BUSY && !w_done) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign w_timeout = (r_state == ST_BUSY) &&
                       (r_cnt == CNT_W'(TIMEOUT_CYCLES));
    // A real response in the timeout cycle is a normal completion.
    assign w_err     = w_timeout && !S_VALID;
`else
    assign w_timeout = 1'b0;
    assign w_err     = 1'b0;
`endif

    always_comb begin
        w_err_data = '0;
        for (int b = 0; b < DATA_W; b++) begin
            w_err_data[b] = ARB_ERR_PATTERN[b % 32];
        end
    end

    assign M_VALID = {N_MASTERS{w_done}} & r_grant;
    assign M_RDATA = w_err ? w_err_data : S_RDATA;
    assign M_ERR   = w_done && w_err;

    assign S_REQ   = r_s_req;
    assign S_WE    = r_s_we;
    assign S_BE    = r_s_be;
    assign S_ADDR  = r_s_addr;
    assign S_WDATA = r_s_wdata;
    assign GRANT   = r_grant;

endmodule

// File: tb/tb_edusoc_data_arbiter.sv
// Directed self-checking bench for edusoc_data_arbiter (4 masters).
// Timeout scenario is exercised only when ARB_TIMEOUT_EN is defined.
module tb_edusoc_data_arbiter;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = DW / 8;

    logic            clk;
    logic            rst_n;
    logic [N-1:0]    m_req;
    logic [N-1:0]    m_we;
    logic [N*BW-1:0] m_be;
    logic [N*AW-1:0] m_addr;
    logic [N*DW-1:0] m_wdata;
    logic [N-1:0]    m_valid;
    logic [DW-1:0]   m_rdata;
    logic            m_err;
    logic            s_req;
    logic            s_we;
    logic [BW-1:0]   s_be;
    logic [AW-1:0]   s_addr;
    logic [DW-1:0]   s_wdata;
    logic            s_valid;
    logic [DW-1:0]   s_rdata;
    logic [N-1:0]    grant;

    int vecs;
    int errs;

    edusoc_data_arbiter #(
        .N_MASTERS      (N),
        .ADDR_W         (AW),
        .DATA_W         (DW),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .CLK     (clk),
        .RESN    (rst_n),
        .M_REQ   (m_req),
        .M_WE    (m_we),
        .M_BE    (m_be),
        .M_ADDR  (m_addr),
        .M_WDATA (m_wdata),
        .M_VALID (m_valid),
        .M_RDATA (m_rdata),
        .M_ERR   (m_err),
        .S_REQ   (s_req),
        .S_WE    (s_we),
        .S_BE    (s_be),
        .S_ADDR  (s_addr),
        .S_WDATA (s_wdata),
        .S_VALID (s_valid),
        .S_RDATA (s_rdata),
        .GRANT   (grant)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        m_req   = '0;
        m_we    = '0;
        m_be    = '0;
        m_addr  = '0;
        m_wdata = '0;
        s_valid = 1'b0;
        s_rdata = '0;
        #1;
        vecs++;
        if (s_req !== 1'b0) begin
            errs++; $display("FAIL reset_sreq got %0h want 0", s_req);
        end
        vecs++;
        if (grant !== 4'b0000) begin
            errs++; $display("FAIL reset_grant got %0h want 0", grant);
        end
        vecs++;
        if ({s_we, s_be, s_addr, s_wdata} !== '0) begin
            errs++; $display("FAIL reset_sbus got %0h/%0h/%0h/%0h want 0",
                             s_we, s_be, s_addr, s_wdata);
        end
        vecs++;
        if ({m_valid, m_err} !== 5'b0) begin
            errs++; $display("FAIL reset_mvalid got %0h/%0h want 0",
                             m_valid, m_err);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_single_read();
        @(negedge clk);
        m_req[0]       = 1'b1;
        m_we[0]        = 1'b0;
        m_addr[31:0]   = 32'h100;
        #1;
        vecs++;
        if (s_req !== 1'b0) begin
            errs++; $display("FAIL rd_sreq_t got %0h want 0", s_req);
        end
        @(negedge clk);
        vecs++;
        if ({s_req, grant} !== 5'b1_0001) begin
            errs++; $display("FAIL rd_sreq_t1 got %0h/%0h want 1/1", s_req, grant);
        end
        vecs++;
        if (s_addr !== 32'h100 || s_we !== 1'b0) begin
            errs++; $display("FAIL rd_saddr got %0h/%0h want 100/0", s_addr, s_we);
        end
        @(negedge clk);
        @(negedge clk);
        s_valid = 1'b1;
        s_rdata = 32'h12345678;
        #1;
        vecs++;
        if (m_valid !== 4'b0001 || m_rdata !== 32'h12345678) begin
            errs++; $display("FAIL rd_mvalid got %0h/%0h want 1/12345678",
                             m_valid, m_rdata);
        end
        @(negedge clk);
        s_valid  = 1'b0;
        m_req[0] = 1'b0;
        #1;
        vecs++;
        if ({m_valid, grant, s_req} !== 9'b0) begin
            errs++; $display("FAIL rd_done got %0h/%0h/%0h want 0/0/0",
                             m_valid, grant, s_req);
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_g;
        int         order [5];
        order = '{0, 1, 2, 3, 0};
        do_reset();
        for (int i = 0; i < N; i++) begin
            m_addr[i*AW +: AW] = 32'h2000 + 32'(i * 4);
            m_we[i]            = 1'b0;
        end
        m_req = 4'b1111;
        for (int t = 0; t < 5; t++) begin
            @(negedge clk);
            exp_g = 4'b0001 << order[t];
            vecs++;
            if (grant !== exp_g || s_req !== 1'b1) begin
                errs++; $display("FAIL rr_grant%0d got %0h/%0h want %0h/1",
                                 t, grant, s_req, exp_g);
            end
            vecs++;
            if (s_addr !== 32'h2000 + 32'(order[t] * 4)) begin
                errs++; $display("FAIL rr_addr%0d got %0h want %0h",
                                 t, s_addr, 32'h2000 + 32'(order[t] * 4));
            end
            s_valid = 1'b1;
            s_rdata = 32'(t);
            #1;
            vecs++;
            if (m_valid !== exp_g) begin
                errs++; $display("FAIL rr_mvalid%0d got %0h want %0h",
                                 t, m_valid, exp_g);
            end
            @(negedge clk);
            s_valid = 1'b0;
            if (t == 4) m_req = '0;
            vecs++;
            if (s_req !== 1'b0 || grant !== 4'b0) begin
                errs++; $display("FAIL rr_gap%0d got %0h/%0h want 0/0",
                                 t, s_req, grant);
            end
        end
    endtask

    task automatic test_write_hold();
        @(negedge clk);
        m_req[1]       = 1'b1;
        m_we[1]        = 1'b1;
        m_be[7:4]      = 4'b0011;
        m_addr[63:32]  = 32'h300;
        m_wdata[63:32] = 32'hAABBCCDD;
        @(negedge clk);
        vecs++;
        if (grant !== 4'b0010 || s_we !== 1'b1 || s_be !== 4'b0011) begin
            errs++; $display("FAIL wr_latch got %0h/%0h/%0h want 2/1/3",
                             grant, s_we, s_be);
        end
        m_addr[63:32]  = 32'h999;
        m_wdata[63:32] = 32'h11111111;
        m_be[7:4]      = 4'b1100;
        m_we[1]        = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            vecs++;
            if (s_addr !== 32'h300 || s_wdata !== 32'hAABBCCDD ||
                s_be !== 4'b0011 || s_we !== 1'b1) begin
                errs++; $display("FAIL wr_hold%0d got %0h/%0h/%0h want 300/aabbccdd/3",
                                 c, s_addr, s_wdata, s_be);
            end
        end
        s_valid = 1'b1;
        #1;
        vecs++;
        if (m_valid !== 4'b0010) begin
            errs++; $display("FAIL wr_mvalid got %0h want 2", m_valid);
        end
        @(negedge clk);
        s_valid  = 1'b0;
        m_req[1] = 1'b0;
    endtask

    task automatic test_spurious();
        @(negedge clk);
        s_valid = 1'b1;
        #1;
        vecs++;
        if (m_valid !== 4'b0) begin
            errs++; $display("FAIL spur_mvalid got %0h want 0", m_valid);
        end
        @(negedge clk);
        s_valid = 1'b0;
        vecs++;
        if (s_req !== 1'b0 || grant !== 4'b0) begin
            errs++; $display("FAIL spur_idle got %0h/%0h want 0/0", s_req, grant);
        end
        m_req[0]     = 1'b1;
        m_addr[31:0] = 32'h400;
        @(negedge clk);
        vecs++;
        if (grant !== 4'b0001 || s_addr !== 32'h400) begin
            errs++; $display("FAIL lone_grant got %0h/%0h want 1/400",
                             grant, s_addr);
        end
        s_valid = 1'b1;
        @(negedge clk);
        s_valid = 1'b0;
        m_req   = '0;
    endtask

    task automatic test_reset_busy();
        @(negedge clk);
        m_req[2] = 1'b1;
        @(negedge clk);
        vecs++;
        if (grant !== 4'b0100 || s_req !== 1'b1) begin
            errs++; $display("FAIL rb_pre got %0h/%0h want 4/1", grant, s_req);
        end
        #2;
        rst_n = 1'b0;
        #1;
        vecs++;
        if (s_req !== 1'b0 || grant !== 4'b0) begin
            errs++; $display("FAIL rb_async got %0h/%0h want 0/0", s_req, grant);
        end
        m_req = 4'b0101;
        @(negedge clk);
        rst_n   = 1'b1;
        s_valid = 1'b1;
        #1;
        vecs++;
        if (m_valid !== 4'b0) begin
            errs++; $display("FAIL rb_late_valid got %0h want 0", m_valid);
        end
        @(negedge clk);
        s_valid = 1'b0;
        vecs++;
        if (grant !== 4'b0001) begin
            errs++; $display("FAIL rb_ptr0 got %0h want 1", grant);
        end
        s_valid = 1'b1;
        #1;
        vecs++;
        if (m_valid !== 4'b0001) begin
            errs++; $display("FAIL rb_done got %0h want 1", m_valid);
        end
        @(negedge clk);
        s_valid = 1'b0;
        m_req   = '0;
    endtask

`ifdef ARB_TIMEOUT_EN
    task automatic test_timeout();
        int busy;
        bit seen;
        busy = 0;
        seen = 1'b0;
        @(negedge clk);
        m_req[3] = 1'b1;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            #1;
            if (s_req === 1'b1) busy++;
            if (m_valid !== 4'b0) begin
                seen = 1'b1;
                vecs++;
                if (m_valid !== 4'b1000 || m_err !== 1'b1 ||
                    m_rdata !== 32'hDEADBEEF || busy != 9) begin
                    errs++; $display("FAIL to_pulse got %0h/%0h/%0h/%0d want 8/1/deadbeef/9",
                                     m_valid, m_err, m_rdata, busy);
                end
            end
        end
        vecs++;
        if (!seen) begin
            errs++; $display("FAIL to_missing got none want pulse");
        end
        @(negedge clk);
        m_req[3] = 1'b0;
        m_req[0] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        s_valid = 1'b1;
        s_rdata = 32'h55;
        #1;
        vecs++;
        if (m_valid !== 4'b0001 || m_err !== 1'b0 || m_rdata !== 32'h55) begin
            errs++; $display("FAIL to_normal got %0h/%0h/%0h want 1/0/55",
                             m_valid, m_err, m_rdata);
        end
        @(negedge clk);
        s_valid = 1'b0;
        m_req   = '0;
    endtask
`endif

    initial begin
        vecs = 0;
        errs = 0;
        test_reset();
        test_single_read();
        test_round_robin();
        test_write_hold();
        test_spurious();
        test_reset_busy();
`ifdef ARB_TIMEOUT_EN
        test_timeout();
`endif
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
